// File: rtl/mem_access_ctrl_if.sv
// Word-wide data memory bus between the load/store unit and the data memory.
interface mem_access_ctrl_if;
  logic        cs;
  logic        rw;
  logic [3:0]  be;
  logic [29:0] addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        ready;

  modport master (
    output cs, rw, be, addr, data_out,
    input  data_in, ready
  );

  modport slave (
    input  cs, rw, be, addr, data_out,
    output data_in, ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store unit: aligns byte/half/word accesses onto a word memory, runs one access
// per request, and returns lane-extracted, sign/zero-extended load data.
module mem_access_ctrl #(
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [31:0]         vaddr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                busy,
  output logic                done,
  output logic                align_err,
  output logic                bus_err,
  mem_access_ctrl_if.master   mem
);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StResp} state_e;

  localparam logic [7:0] LatLast     = 8'(READ_LAT - 1);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  lat_q, lat_d;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        wr_q, sext_q;
  logic [3:0]  be_q;
  logic [31:0] dout_q;
  logic [31:0] rdata_q;
  logic        align_err_q, align_err_d;
  logic        bus_err_q, bus_err_d;
  logic        accept, capture, misaligned;
  logic [3:0]  be_req;
  logic [31:0] dout_req;
  logic [31:0] load_val;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Request decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    misaligned = 1'b0;
    be_req     = 4'b0000;
    dout_req   = wdata;
    unique case (size)
      2'b00: begin
        be_req   = 4'b0001 << vaddr[1:0];
        dout_req = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = vaddr[0];
        be_req     = vaddr[1] ? 4'b1100 : 4'b0011;
        dout_req   = {2{wdata[15:0]}};
      end
      2'b10: begin
        misaligned = (vaddr[1:0] != 2'b00);
        be_req     = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched access shape.
  always_comb begin
    lane_b = mem.data_in[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? mem.data_in[31:16] : mem.data_in[15:0];
    unique case (size_q)
      2'b00:   load_val = {{24{sext_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{sext_q & lane_h[15]}}, lane_h};
      default: load_val = mem.data_in;
    endcase
  end

  // Next-state logic for the access sequence and its timeout/latency counters.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    accept      = 1'b0;
    capture     = 1'b0;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (misaligned) begin
            align_err_d = 1'b1;
          end else begin
            accept  = 1'b1;
            cnt_d   = 8'd0;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (mem.ready) begin
          if (wr_q) begin
            state_d = StResp;
          end else begin
            lat_d   = 8'd0;
            state_d = StRdWait;
          end
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == TimeoutLast)) begin
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRdWait: begin
        if (lat_q == LatLast) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, access latches and result registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      lat_q       <= 8'd0;
      addr_q      <= 30'd0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      wr_q        <= 1'b0;
      sext_q      <= 1'b0;
      be_q        <= 4'b0000;
      dout_q      <= 32'd0;
      rdata_q     <= 32'd0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
      if (accept) begin
        addr_q <= vaddr[31:2];
        off_q  <= vaddr[1:0];
        size_q <= size;
        wr_q   <= wr;
        sext_q <= sign_ext;
        be_q   <= be_req;
        dout_q <= dout_req;
      end
      if (capture) begin
        rdata_q <= load_val;
      end
    end
  end

  // Outputs decode registered state only; memory strobes are live in ISSUE alone.
  always_comb begin
    busy         = (state_q == StIssue) || (state_q == StRdWait);
    done         = (state_q == StResp);
    align_err    = align_err_q;
    bus_err      = bus_err_q;
    rdata        = rdata_q;
    mem.cs       = (state_q == StIssue);
    mem.rw       = (state_q == StIssue) && wr_q;
    mem.be       = (state_q == StIssue) ? be_q : 4'b0000;
    mem.addr     = addr_q;
    mem.data_out = dout_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected events computed from a
// byte-level shadow memory; a monitor pops and compares when the DUT reports completion.
module tb_mem_access_ctrl;

  localparam int ReadLat = 1;
  localparam int Timeout = 3;

  typedef struct {
    logic [2:0]  kind;   // {done, align_err, bus_err}
    bit          is_load;
    logic [31:0] rdata;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr, sign_ext;
  logic [1:0]  size;
  logic [31:0] vaddr, wdata;
  logic [31:0] rdata;
  logic        busy, done, align_err, bus_err;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .READ_LAT    (ReadLat),
    .TIMEOUT_CYC (Timeout)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .sign_ext  (sign_ext),
    .vaddr     (vaddr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .align_err (align_err),
    .bus_err   (bus_err),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          seen = 0;
  exp_t        sb[$];
  logic [7:0]  shadow[64];
  logic [31:0] mem_arr[16];
  int          k_cur = 0;
  bit          exp_cs_ok = 1'b0;
  logic [29:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_dout;
  bit          exp_rw;
  int          n_issue = 0;
  int          rd_age = -1;
  int          rd_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model: random ready stalls, byte-lane writes, read data only in its valid cycle.
  always @(negedge clk) begin
    if (rd_age >= 0) rd_age++;
    if (rd_age == ReadLat) bus.data_in = mem_arr[rd_idx];
    else bus.data_in = $urandom;
    if (rd_age > ReadLat) rd_age = -1;
    if (bus.cs) begin
      if (!exp_cs_ok) check("cs_unexpected", 32'(bus.cs), 32'd0);
      check("mem_addr", 32'(bus.addr), 32'(exp_addr));
      check("mem_be", 32'(bus.be), 32'(exp_be));
      check("mem_rw", 32'(bus.rw), 32'(exp_rw));
      if (exp_rw) check("mem_dout", bus.data_out, exp_dout);
      if (bus.rw) begin
        for (int i = 0; i < 4; i++)
          if (bus.be[i]) mem_arr[bus.addr[3:0]][8*i +: 8] = bus.data_out[8*i +: 8];
      end
      bus.ready = (n_issue >= k_cur);
      n_issue++;
      if (bus.ready && !bus.rw) begin
        rd_age = 0;
        rd_idx = int'(bus.addr[3:0]);
      end
    end else begin
      n_issue   = 0;
      bus.ready = 1'($urandom % 2);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT reports a completion event.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && (done || align_err || bus_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {29'd0, done, align_err, bus_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("event_kind", {29'd0, done, align_err, bus_err}, {29'd0, e.kind});
        check("latency", 32'(cyc - e.t0), 32'(e.lat));
        if (e.is_load && e.kind == 3'b100) check("rdata", rdata, e.rdata);
      end
      seen++;
    end
  end

  // Reference model: computes the expected outcome of one request and drives it.
  task automatic start(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] va,
                       input logic [31:0] wd, input int k, output bit mis);
    exp_t e;
    int   n, off, base;
    logic [31:0] v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = int'(va[1:0]);
    base = int'(va[5:0]);
    mis  = (sz == 2'd3) || ((off % n) != 0);
    e.t0 = cyc;
    e.is_load = !w;
    e.rdata = 32'd0;
    if (mis) begin
      exp_cs_ok = 1'b0;
      e.kind = 3'b010;
      e.lat  = 1;
    end else begin
      exp_cs_ok = 1'b1;
      k_cur     = k;
      exp_addr  = va[31:2];
      exp_rw    = w;
      exp_be    = 4'b0000;
      for (int i = 0; i < n; i++) exp_be[off+i] = 1'b1;
      for (int i = 0; i < 4; i++) exp_dout[8*i +: 8] = wd[8*(i % n) +: 8];
      if (w) begin
        // Memory writes on every RW=1 edge, so even a timed-out store lands.
        for (int i = 0; i < n; i++) shadow[base+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(shadow[base+i]) << (8*i));
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e.rdata = v;
      end
      if (k >= Timeout) begin
        e.kind = 3'b001;
        e.lat  = Timeout + 1;
      end else begin
        e.kind = 3'b100;
        e.lat  = 2 + k + (w ? 0 : ReadLat);
      end
    end
    sb.push_back(e);
    wr = w; size = sz; sign_ext = sx; vaddr = va; wdata = wd; req = 1'b1;
  endtask

  // Full transaction: issue, then wait (bounded) for its event, spraying ignored Reqs while busy.
  task automatic issue(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] va,
                       input logic [31:0] wd, input int k);
    int target, n;
    bit mis;
    target = seen + 1;
    start(w, sz, sx, va, wd, k, mis);
    @(negedge clk);
    if (mis) check("align_busy", 32'(busy), 32'd0);
    n = 0;
    while (seen < target && n < 60) begin
      if (busy) begin
        req = 1'($urandom % 2); wr = 1'($urandom % 2); size = 2'($urandom);
        vaddr = $urandom; wdata = $urandom;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if (seen < target) check("event_timeout", 32'(seen), 32'(target));
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_flags"}, {28'd0, busy, done, align_err, bus_err}, 32'd0);
    check({tag, "_strobes"}, {26'd0, bus.cs, bus.rw, bus.be}, 32'd0);
    check({tag, "_addr"}, 32'(bus.addr), 32'd0);
    check({tag, "_dout"}, bus.data_out, 32'd0);
  endtask

  initial begin
    bit mis;
    for (int i = 0; i < 64; i++) shadow[i] = 8'd0;
    for (int i = 0; i < 16; i++) mem_arr[i] = 32'd0;
    bus.ready = 1'b0; bus.data_in = 32'd0;
    req = 1'b0; wr = 1'b0; size = 2'd0; sign_ext = 1'b0; vaddr = 32'd0; wdata = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed: stores, lane loads, misaligned, timeout, late ready.
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 0);
    issue(1'b1, 2'd0, 1'b0, 32'h43, 32'h000000A5, 0);
    issue(1'b1, 2'd1, 1'b0, 32'h42, 32'h00001234, 1);
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h80017FFF, 0);
    issue(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 0);
    issue(1'b0, 2'd0, 1'b1, 32'h40, 32'h0, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 0);
    issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 0);
    issue(1'b1, 2'd2, 1'b0, 32'h44, 32'h11223344, 3);
    issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 5);
    issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 2);

    // Reset during RDWAIT aborts silently; a following load completes normally.
    start(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, mis);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    exp_cs_ok = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] va;
      va = {26'($urandom), 6'($urandom)};
      issue(1'($urandom % 2), 2'($urandom), 1'($urandom % 2), va, $urandom,
            int'($urandom_range(0, 4)));
    end

    repeat (5) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
